// File: rtl/mem_ctrl_bus_pkg.sv
// Shared definitions for the memory-stage controller: op codes, bus
// direction, FSM states and small op-decode helpers.
package mem_ctrl_bus_pkg;

   localparam int MEM_OP_W = 4;

   typedef enum logic [MEM_OP_W-1:0] {
      MEM_OP_NOP  = 4'd0,
      MEM_OP_LDW  = 4'd1,
      MEM_OP_LDH  = 4'd2,
      MEM_OP_LDHU = 4'd3,
      MEM_OP_LDB  = 4'd4,
      MEM_OP_LDBU = 4'd5,
      MEM_OP_STW  = 4'd6,
      MEM_OP_STH  = 4'd7,
      MEM_OP_STB  = 4'd8
   } mem_op_e;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   typedef enum logic {ST_IDLE, ST_ACCESS} state_e;

   typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

   // Access size of an op; undefined codes decode as SZ_NONE (treated as NOP).
   function automatic size_e op_size(input logic [MEM_OP_W-1:0] op);
      case (op)
         MEM_OP_LDW, MEM_OP_STW:              return SZ_WORD;
         MEM_OP_LDH, MEM_OP_LDHU, MEM_OP_STH: return SZ_HALF;
         MEM_OP_LDB, MEM_OP_LDBU, MEM_OP_STB: return SZ_BYTE;
         default:                             return SZ_NONE;
      endcase
   endfunction

   function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
      return (op >= MEM_OP_LDW) && (op <= MEM_OP_LDBU);
   endfunction

   function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
      return (op >= MEM_OP_STW) && (op <= MEM_OP_STB);
   endfunction

endpackage

// File: rtl/mem_ctrl_bus_if.sv
// System bus seen by the memory stage: strobe/direction/address/lanes out,
// read data and active-low ready back.
interface mem_ctrl_bus_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 30
) ();
   logic                  bus_as_;
   logic                  bus_rw;
   logic [ADDR_W-1:0]     bus_addr;
   logic [DATA_W/8-1:0]   bus_be;
   logic [DATA_W-1:0]     bus_wr_data;
   logic [DATA_W-1:0]     bus_rd_data;
   logic                  bus_rdy_;

   modport master (
      output bus_as_, bus_rw, bus_addr, bus_be, bus_wr_data,
      input  bus_rd_data, bus_rdy_
   );

   modport slave (
      input  bus_as_, bus_rw, bus_addr, bus_be, bus_wr_data,
      output bus_rd_data, bus_rdy_
   );
endinterface

// File: rtl/mem_ctrl_bus_lane_align.sv
// Byte-lane steering: store replication + byte enables + alignment check on
// the request side, lane extraction + sign/zero extension on the response side.
module mem_ctrl_bus_lane_align
   import mem_ctrl_bus_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [MEM_OP_W-1:0]          req_op_i,
   input  logic [$clog2(DATA_W/8)-1:0]  req_off_i,
   input  logic [DATA_W-1:0]            req_wr_data_i,
   output logic                         req_misalign_o,
   output logic [DATA_W/8-1:0]          req_be_o,
   output logic [DATA_W-1:0]            req_wr_lanes_o,
   input  logic [MEM_OP_W-1:0]          rsp_op_i,
   input  logic [$clog2(DATA_W/8)-1:0]  rsp_off_i,
   input  logic [DATA_W-1:0]            rsp_rd_data_i,
   output logic [DATA_W-1:0]            rsp_data_o
);
   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] shifted;

   // Request side: replicate the right-aligned store data into every lane so
   // the byte enables alone select where it lands.
   always_comb begin
      req_misalign_o = 1'b0;
      req_be_o       = '0;
      req_wr_lanes_o = '0;
      case (op_size(req_op_i))
         SZ_BYTE: begin
            req_be_o       = NB'(1) << req_off_i;
            req_wr_lanes_o = {NB{req_wr_data_i[7:0]}};
         end
         SZ_HALF: begin
            req_misalign_o = req_off_i[0];
            req_be_o       = NB'(3) << req_off_i;
            req_wr_lanes_o = {(NB/2){req_wr_data_i[15:0]}};
         end
         SZ_WORD: begin
            req_misalign_o = |req_off_i;
            req_be_o       = '1;
            req_wr_lanes_o = req_wr_data_i;
         end
         default: ;
      endcase
   end

   assign shifted = rsp_rd_data_i >> {rsp_off_i, 3'b000};

   // Response side: pull the addressed lane down to bit 0 and extend it.
   always_comb begin
      rsp_data_o = '0;
      case (rsp_op_i)
         MEM_OP_LDW:  rsp_data_o = rsp_rd_data_i;
         MEM_OP_LDH:  rsp_data_o = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
         MEM_OP_LDHU: rsp_data_o = {{(DATA_W-16){1'b0}}, shifted[15:0]};
         MEM_OP_LDB:  rsp_data_o = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
         MEM_OP_LDBU: rsp_data_o = {{(DATA_W-8){1'b0}}, shifted[7:0]};
         default:     rsp_data_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_ctrl_bus.sv
// Memory-stage controller between the EX/MEM register and the system bus.
// Non-memory ops pass through in one cycle; memory ops run a registered bus
// cycle with wait states, stall upstream, and abort on timeout.
module mem_ctrl_bus
   import mem_ctrl_bus_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 30,
   parameter int TIMEOUT = 255
) (
   input  logic                                 clk,
   input  logic                                 reset_,
   input  logic                                 ex_en_,
   input  logic [MEM_OP_W-1:0]                  ex_mem_op,
   input  logic [DATA_W-1:0]                    ex_mem_wr_data,
   input  logic [ADDR_W+$clog2(DATA_W/8)-1:0]   ex_out,
   output logic                                 stall,
   output logic [DATA_W-1:0]                    out,
   output logic                                 miss_align,
   output logic                                 bus_err,
   mem_ctrl_bus_if.master                       bus
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int BA_W  = ADDR_W + OFF_W;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [MEM_OP_W-1:0] op_q, op_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [DATA_W-1:0]   out_q, out_d;
   logic                miss_q, miss_d;
   logic                err_q, err_d;
   logic                as_q, as_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [NB-1:0]       be_q, be_d;
   logic [DATA_W-1:0]   wdat_q, wdat_d;

   logic                req_misalign;
   logic [NB-1:0]       req_be;
   logic [DATA_W-1:0]   req_lanes;
   logic [DATA_W-1:0]   rsp_data;
   logic                req_is_load, req_is_mem;

   mem_ctrl_bus_lane_align #(.DATA_W(DATA_W)) u_lane (
      .req_op_i       (ex_mem_op),
      .req_off_i      (ex_out[OFF_W-1:0]),
      .req_wr_data_i  (ex_mem_wr_data),
      .req_misalign_o (req_misalign),
      .req_be_o       (req_be),
      .req_wr_lanes_o (req_lanes),
      .rsp_op_i       (op_q),
      .rsp_off_i      (off_q),
      .rsp_rd_data_i  (bus.bus_rd_data),
      .rsp_data_o     (rsp_data)
   );

   assign req_is_load = op_is_load(ex_mem_op);
   assign req_is_mem  = req_is_load || op_is_store(ex_mem_op);
   assign cnt_inc     = cnt_q + CNT_W'(1);

   // Next-state: accept requests in IDLE, wait for ready or timeout in ACCESS.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      miss_d  = 1'b0;
      err_d   = 1'b0;
      as_d    = as_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdat_d  = wdat_q;
      stall   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ex_en_) begin
               out_d = '0;
            end else if (!req_is_mem) begin
               out_d = DATA_W'(ex_out);
            end else if (req_misalign) begin
               out_d  = '0;
               miss_d = 1'b1;
            end else begin
               // Hold EX/MEM this cycle; out keeps its value until the bus completes.
               stall   = 1'b1;
               op_d    = ex_mem_op;
               off_d   = ex_out[OFF_W-1:0];
               addr_d  = ex_out[BA_W-1:OFF_W];
               be_d    = req_be;
               rw_d    = req_is_load ? READ : WRITE;
               wdat_d  = req_is_load ? '0 : req_lanes;
               as_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            stall = bus.bus_rdy_;
            if (!bus.bus_rdy_) begin
               out_d   = op_is_load(op_q) ? rsp_data : '0;
               as_d    = 1'b1;
               be_d    = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               out_d   = '0;
               err_d   = 1'b1;
               as_d    = 1'b1;
               be_d    = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset drops the strobe without waiting for clk.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= ST_IDLE;
         op_q    <= MEM_OP_NOP;
         off_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         miss_q  <= 1'b0;
         err_q   <= 1'b0;
         as_q    <= 1'b1;
         rw_q    <= READ;
         addr_q  <= '0;
         be_q    <= '0;
         wdat_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         miss_q  <= miss_d;
         err_q   <= err_d;
         as_q    <= as_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdat_q  <= wdat_d;
      end
   end

   assign out             = out_q;
   assign miss_align      = miss_q;
   assign bus_err         = err_q;
   assign bus.bus_as_     = as_q;
   assign bus.bus_rw      = rw_q;
   assign bus.bus_addr    = addr_q;
   assign bus.bus_be      = be_q;
   assign bus.bus_wr_data = wdat_q;

endmodule

// File: tb/tb_mem_ctrl_bus.sv
// Self-checking bench for mem_ctrl_bus (DATA_W=32, ADDR_W=30, TIMEOUT=4).
module tb_mem_ctrl_bus;
   import mem_ctrl_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset_;
   logic        ex_en_;
   logic [3:0]  ex_mem_op;
   logic [31:0] ex_mem_wr_data;
   logic [31:0] ex_out;
   logic        stall;
   logic [31:0] out;
   logic        miss_align;
   logic        bus_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   mem_ctrl_bus_if #(.DATA_W(32), .ADDR_W(30)) bif ();

   mem_ctrl_bus #(.DATA_W(32), .ADDR_W(30), .TIMEOUT(4)) dut (
      .clk            (clk),
      .reset_         (reset_),
      .ex_en_         (ex_en_),
      .ex_mem_op      (ex_mem_op),
      .ex_mem_wr_data (ex_mem_wr_data),
      .ex_out         (ex_out),
      .stall          (stall),
      .out            (out),
      .miss_align     (miss_align),
      .bus_err        (bus_err),
      .bus            (bif.master)
   );

   // Drives one aligned access with a fixed number of wait states and records
   // what the bus and pipeline side showed; comparisons are done by callers.
   task automatic run_access(input logic [3:0] op, input logic [31:0] addr, wdata, rdata,
                             input int waits, output int stall_cnt, output int as_cnt,
                             output logic [3:0] be_s, output logic [31:0] wd_s,
                             output logic rw_s, output logic [29:0] addr_s,
                             output logic [31:0] out_s);
      be_s = '0; wd_s = '0; rw_s = 1'b0; addr_s = '0;
      @(posedge clk); #1;
      ex_en_ = 1'b0; ex_mem_op = op; ex_out = addr; ex_mem_wr_data = wdata;
      bif.bus_rdy_ = 1'b1; bif.bus_rd_data = $urandom;
      stall_cnt = 0; as_cnt = 0;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (!bif.bus_as_) as_cnt++;
      for (int k = 0; k <= waits; k++) begin
         @(posedge clk); #1;
         if (k == waits) begin bif.bus_rdy_ = 1'b0; bif.bus_rd_data = rdata; end
         @(negedge clk);
         if (stall) stall_cnt++;
         if (!bif.bus_as_) as_cnt++;
         if (k == 0) begin
            be_s = bif.bus_be; wd_s = bif.bus_wr_data; rw_s = bif.bus_rw; addr_s = bif.bus_addr;
         end
      end
      @(posedge clk); #1;
      ex_en_ = 1'b1; ex_mem_op = MEM_OP_NOP; bif.bus_rdy_ = 1'b1; bif.bus_rd_data = $urandom;
      @(negedge clk);
      out_s = out;
      if (!bif.bus_as_) as_cnt++;
   endtask

   task automatic test_reset();
      reset_ = 1'b0; ex_en_ = 1'b1; ex_mem_op = MEM_OP_NOP; ex_mem_wr_data = '0; ex_out = '0;
      bif.bus_rdy_ = 1'b1; bif.bus_rd_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out, miss_align, bus_err, stall} !== 35'h0) begin
         errors++; $display("FAIL reset_pipe got %h exp 0", {out, miss_align, bus_err, stall});
      end
      checks++;
      if ({bif.bus_as_, bif.bus_rw, bif.bus_addr, bif.bus_be, bif.bus_wr_data} !== {1'b1, 1'b1, 30'h0, 4'h0, 32'h0}) begin
         errors++; $display("FAIL reset_bus got as=%b rw=%b addr=%h be=%h wd=%h exp as=1 rw=1 zeros",
                            bif.bus_as_, bif.bus_rw, bif.bus_addr, bif.bus_be, bif.bus_wr_data);
      end
      reset_ = 1'b1;
   endtask

   task automatic test_passthrough();
      logic [31:0] e;
      // valid NOP, invalid slot, undefined op code
      @(posedge clk); #1;
      ex_en_ = 1'b0; ex_mem_op = MEM_OP_NOP; ex_out = 32'hCAFE0001; exp_q.push_back(32'hCAFE0001);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall got %b exp 0", stall); end
      @(posedge clk); #1;
      ex_en_ = 1'b1; ex_out = 32'h0000FFFF; exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (out !== e) begin errors++; $display("FAIL pass_nop got %h exp %h", out, e); end
      @(posedge clk); #1;
      ex_en_ = 1'b0; ex_mem_op = 4'hB; ex_out = 32'h00001357; exp_q.push_back(32'h00001357);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (out !== e) begin errors++; $display("FAIL pass_invalid got %h exp %h", out, e); end
      @(posedge clk); #1;
      ex_en_ = 1'b1; ex_mem_op = MEM_OP_NOP;
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({out, bif.bus_as_} !== {e, 1'b1}) begin
         errors++; $display("FAIL pass_undef_op got out=%h as=%b exp out=%h as=1", out, bif.bus_as_, e);
      end
   endtask

   task automatic test_ldw();
      int sc, ac; logic [3:0] be; logic [31:0] wd, o, e; logic rw; logic [29:0] a;
      exp_q.push_back(32'hDEADBEEF);
      run_access(MEM_OP_LDW, 32'h100, 32'h0, 32'hDEADBEEF, 2, sc, ac, be, wd, rw, a, o);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL ldw_out got %h exp %h", o, e); end
      checks++;
      if (sc !== 3 || ac !== 3) begin errors++; $display("FAIL ldw_cycles got stall=%0d as=%0d exp 3 3", sc, ac); end
      checks++;
      if ({a, be, rw} !== {30'h40, 4'hF, 1'b1}) begin
         errors++; $display("FAIL ldw_bus got addr=%h be=%b rw=%b exp 40 1111 1", a, be, rw);
      end
   endtask

   task automatic test_loads();
      int sc, ac; logic [3:0] be; logic [31:0] wd, o, e; logic rw; logic [29:0] a;
      logic [3:0]  ops  [7];
      logic [31:0] adr  [7];
      logic [31:0] res  [7];
      logic [3:0]  bes  [7];
      ops = '{MEM_OP_LDB, MEM_OP_LDBU, MEM_OP_LDH, MEM_OP_LDHU, MEM_OP_LDB, MEM_OP_LDH, MEM_OP_LDW};
      adr = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h104};
      res = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011, 32'h00000033, 32'h00002233, 32'h80112233};
      bes = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0001, 4'b0011, 4'b1111};
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(res[i]);
         run_access(ops[i], adr[i], 32'hFFFFFFFF, 32'h80112233, i % 2, sc, ac, be, wd, rw, a, o);
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL load[%0d]_out got %h exp %h", i, o, e); end
         checks++;
         if ({be, rw, a} !== {bes[i], 1'b1, adr[i][31:2]} || sc !== (i % 2) + 1) begin
            errors++; $display("FAIL load[%0d]_bus got be=%b rw=%b addr=%h stall=%0d exp be=%b rw=1 addr=%h stall=%0d",
                               i, be, rw, a, sc, bes[i], adr[i][31:2], (i % 2) + 1);
         end
      end
   endtask

   task automatic test_stores();
      int sc, ac; logic [3:0] be; logic [31:0] wd, o, e; logic rw; logic [29:0] a;
      logic [3:0]  ops [4];
      logic [31:0] adr [4];
      logic [31:0] dat [4];
      logic [31:0] lan [4];
      logic [3:0]  bes [4];
      ops = '{MEM_OP_STB, MEM_OP_STH, MEM_OP_STW, MEM_OP_STB};
      adr = '{32'h101, 32'h102, 32'h104, 32'h100};
      dat = '{32'h000000A5, 32'h0000BEEF, 32'h12345678, 32'hFFFFFF5A};
      lan = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h12345678, 32'h5A5A5A5A};
      bes = '{4'b0010, 4'b1100, 4'b1111, 4'b0001};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'h0);
         run_access(ops[i], adr[i], dat[i], 32'h87654321, i % 3, sc, ac, be, wd, rw, a, o);
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL store[%0d]_out got %h exp %h", i, o, e); end
         checks++;
         if ({be, wd, rw, a} !== {bes[i], lan[i], 1'b0, adr[i][31:2]} || ac !== (i % 3) + 1) begin
            errors++; $display("FAIL store[%0d]_bus got be=%b wd=%h rw=%b addr=%h as=%0d exp be=%b wd=%h rw=0 addr=%h as=%0d",
                               i, be, wd, rw, a, ac, bes[i], lan[i], adr[i][31:2], (i % 3) + 1);
         end
      end
   endtask

   task automatic test_misalign();
      logic [31:0] e;
      logic [3:0]  ops [4];
      logic [31:0] adr [4];
      ops = '{MEM_OP_LDW, MEM_OP_LDH, MEM_OP_STW, MEM_OP_STH};
      adr = '{32'h102, 32'h101, 32'h101, 32'h103};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         ex_en_ = 1'b0; ex_mem_op = MEM_OP_NOP; ex_out = 32'h55550000 | i; exp_q.push_back(32'h55550000 | i);
         @(posedge clk); #1;
         ex_mem_op = ops[i]; ex_out = adr[i]; ex_mem_wr_data = 32'h11223344; exp_q.push_back(32'h0);
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if ({out, stall} !== {e, 1'b0}) begin
            errors++; $display("FAIL mis[%0d]_req got out=%h stall=%b exp out=%h stall=0", i, out, stall, e);
         end
         @(posedge clk); #1;
         ex_en_ = 1'b1; ex_mem_op = MEM_OP_NOP;
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if ({out, miss_align, bif.bus_as_} !== {e, 1'b1, 1'b1}) begin
            errors++; $display("FAIL mis[%0d]_pulse got out=%h miss=%b as=%b exp out=%h miss=1 as=1", i, out, miss_align, bif.bus_as_, e);
         end
         @(negedge clk);
         checks++;
         if (miss_align !== 1'b0) begin errors++; $display("FAIL mis[%0d]_width got %b exp 0", i, miss_align); end
      end
   endtask

   task automatic test_timeout();
      int ac = 0, ec = 0, sc = 0;
      logic [31:0] e;
      @(posedge clk); #1;
      ex_en_ = 1'b0; ex_mem_op = MEM_OP_NOP; ex_out = 32'h00000777;
      @(posedge clk); #1;
      ex_mem_op = MEM_OP_LDW; ex_out = 32'h200; bif.bus_rdy_ = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (!bif.bus_as_) ac++;
         if (bus_err) ec++;
         if (stall) sc++;
      end
      @(posedge clk); #1;
      ex_en_ = 1'b1; ex_mem_op = MEM_OP_NOP;
      @(negedge clk);
      checks++;
      if (ac !== 4 || ec !== 0 || sc !== 4) begin
         errors++; $display("FAIL tmo_wait got as=%0d err=%0d stall=%0d exp 4 0 4", ac, ec, sc);
      end
      checks++;
      if ({bus_err, bif.bus_as_, out} !== {1'b1, 1'b1, 32'h0}) begin
         errors++; $display("FAIL tmo_err got err=%b as=%b out=%h exp 1 1 0", bus_err, bif.bus_as_, out);
      end
      @(posedge clk); #1;
      ex_en_ = 1'b0; ex_out = 32'h00000ABC; exp_q.push_back(32'h00000ABC);
      @(negedge clk);
      checks++;
      if ({bus_err, stall, bif.bus_as_} !== 3'b001) begin
         errors++; $display("FAIL tmo_idle got err=%b stall=%b as=%b exp 0 0 1", bus_err, stall, bif.bus_as_);
      end
      @(posedge clk); #1;
      ex_en_ = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (out !== e) begin errors++; $display("FAIL tmo_after got %h exp %h", out, e); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      @(posedge clk); #1;
      ex_en_ = 1'b0; ex_mem_op = MEM_OP_NOP; ex_out = 32'h00000999;
      @(posedge clk); #1;
      ex_mem_op = MEM_OP_LDW; ex_out = 32'h300; bif.bus_rdy_ = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({bif.bus_as_, out} !== {1'b0, 32'h999}) begin
         errors++; $display("FAIL rst_pre got as=%b out=%h exp 0 999", bif.bus_as_, out);
      end
      reset_ = 1'b0;
      #1;
      checks++;
      if ({bif.bus_as_, out} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL rst_async got as=%b out=%h exp 1 0", bif.bus_as_, out);
      end
      ex_en_ = 1'b1; ex_mem_op = MEM_OP_NOP;
      @(posedge clk); #2;
      reset_ = 1'b1;
      @(posedge clk); #1;
      ex_en_ = 1'b0; ex_out = 32'h00001234; exp_q.push_back(32'h00001234);
      @(posedge clk); #1;
      ex_en_ = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({out, bif.bus_as_} !== {e, 1'b1}) begin
         errors++; $display("FAIL rst_after got out=%h as=%b exp %h 1", out, bif.bus_as_, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_passthrough();
      test_ldw();
      test_loads();
      test_stores();
      test_misalign();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
